// File: rtl/io_queue_pkg.sv
// io_queue_pkg: shared sizing helpers and lane-count function for io_multi_deq_ctrl.
//   Default sizing localparams, counter/shift width helpers, and
//   prefix_count(), the length of the leading run of ones in a lane vector.
package io_queue_pkg;

  localparam int unsigned QueueSizeDefault = 8;
  localparam int unsigned EnqWidthDefault  = 2;
  localparam int unsigned DeqWidthDefault  = 2;

  // Widest lane vector prefix_count() accepts; narrower vectors are zero-extended.
  localparam int unsigned MaxLanes = 16;

  // Occupancy counter must represent 0..QUEUE_SIZE inclusive.
  function automatic int unsigned cnt_width(input int unsigned qs);
    return $clog2(qs) + 1;
  endfunction

  // Rotate amounts never reach QUEUE_SIZE (lanes <= QUEUE_SIZE/2).
  function automatic int unsigned shift_width(input int unsigned qs);
    return $clog2(qs);
  endfunction

  function automatic int unsigned prefix_count(input logic [MaxLanes-1:0] vec);
    int unsigned n;
    logic        run;
    n   = 0;
    run = 1'b1;
    for (int i = 0; i < MaxLanes; i++) begin
      run = run & vec[i];
      if (run) n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/io_multi_deq_ctrl_if.sv
// io_multi_deq_ctrl_if: handshake/status bundle of the multi-lane queue controller.
//   master: drives flush, enq_req, deq_fire; observes all status.
//   slave : the controller; drives enq_ready, enq_ptr_oh, enq_alloc_vec,
//           head_valid, head_oh, entry_valid, count, empty, full.
interface io_multi_deq_ctrl_if #(
  parameter int unsigned QUEUE_SIZE = io_queue_pkg::QueueSizeDefault,
  parameter int unsigned ENQ_WIDTH  = io_queue_pkg::EnqWidthDefault,
  parameter int unsigned DEQ_WIDTH  = io_queue_pkg::DeqWidthDefault
);

  logic                                             flush;
  logic [ENQ_WIDTH-1:0]                             enq_req;
  logic                                             enq_ready;
  logic [QUEUE_SIZE-1:0]                            enq_ptr_oh;
  logic [QUEUE_SIZE-1:0]                            enq_alloc_vec;
  logic [DEQ_WIDTH-1:0]                             head_valid;
  logic [DEQ_WIDTH*QUEUE_SIZE-1:0]                  head_oh;
  logic [DEQ_WIDTH-1:0]                             deq_fire;
  logic [QUEUE_SIZE-1:0]                            entry_valid;
  logic [io_queue_pkg::cnt_width(QUEUE_SIZE)-1:0]   count;
  logic                                             empty;
  logic                                             full;

  modport master (
    output flush, enq_req, deq_fire,
    input  enq_ready, enq_ptr_oh, enq_alloc_vec, head_valid, head_oh,
           entry_valid, count, empty, full
  );

  modport slave (
    input  flush, enq_req, deq_fire,
    output enq_ready, enq_ptr_oh, enq_alloc_vec, head_valid, head_oh,
           entry_valid, count, empty, full
  );

endinterface

// File: rtl/oh_rot_left.sv
// oh_rot_left: rotate a one-hot (or any) vector left by a run-time amount.
//   oh_i    : vector to rotate
//   shift_i : rotate amount, must be < Width
//   oh_o    : oh_i rotated left by shift_i
module oh_rot_left #(
  parameter int unsigned Width  = 8,
  parameter int unsigned ShiftW = 3
) (
  input  logic [Width-1:0]  oh_i,
  input  logic [ShiftW-1:0] shift_i,
  output logic [Width-1:0]  oh_o
);

  logic [ShiftW:0] rshift;

  // A shift of 0 gives rshift == Width, which shifts the wrap term out entirely.
  assign rshift = (ShiftW + 1)'(Width) - {1'b0, shift_i};
  assign oh_o   = (oh_i << shift_i) | (oh_i >> rshift);

endmodule

// File: rtl/io_multi_deq_ctrl.sv
// io_multi_deq_ctrl: slot allocator / occupancy tracker for a circular queue with
// ENQ_WIDTH enqueue lanes and DEQ_WIDTH oldest-first dequeue lanes.
//   clock, reset_n : single clock, asynchronous active-low reset
//   bus (slave)    : flush / enq_req / deq_fire in; ready, pointers, allocation
//                    vector, head lanes, occupancy, count, empty, full out.
// All outputs except enq_alloc_vec are functions of registered state only.
module io_multi_deq_ctrl
  import io_queue_pkg::*;
#(
  parameter int unsigned QUEUE_SIZE = QueueSizeDefault,
  parameter int unsigned ENQ_WIDTH  = EnqWidthDefault,
  parameter int unsigned DEQ_WIDTH  = DeqWidthDefault
) (
  input logic                clock,
  input logic                reset_n,
  io_multi_deq_ctrl_if.slave bus
);

  localparam int unsigned CntW = cnt_width(QUEUE_SIZE);
  localparam int unsigned ShW  = shift_width(QUEUE_SIZE);
  localparam logic [QUEUE_SIZE-1:0] SlotZero = QUEUE_SIZE'(1);

  logic [CntW-1:0]       count_q, count_d;
  logic [QUEUE_SIZE-1:0] enq_ptr_q, enq_ptr_d;
  logic [QUEUE_SIZE-1:0] deq_ptr_q, deq_ptr_d;
  logic [QUEUE_SIZE-1:0] valid_q, valid_d;

  logic                  enq_ready;
  logic [ShW-1:0]        nenq, ndeq;
  logic [QUEUE_SIZE-1:0] enq_ptr_rot, deq_ptr_rot;
  logic [QUEUE_SIZE-1:0] alloc_vec, clr_vec;
  logic [QUEUE_SIZE-1:0] enq_lane_oh [ENQ_WIDTH];
  logic [QUEUE_SIZE-1:0] head_lane_oh [DEQ_WIDTH];
  logic [DEQ_WIDTH-1:0]  head_valid;
  logic [DEQ_WIDTH-1:0]  deq_mask;
  logic [MaxLanes-1:0]   deq_vec;

  // Same-cycle dequeues are deliberately not credited, keeping ready off the
  // deq_fire path.
  assign enq_ready = (CntW'(QUEUE_SIZE) - count_q) >= CntW'(ENQ_WIDTH);
  assign nenq      = ShW'($countones(bus.enq_req & {ENQ_WIDTH{enq_ready}}));

  for (genvar j = 0; j < ENQ_WIDTH; j++) begin : g_enq_lane
    oh_rot_left #(.Width(QUEUE_SIZE), .ShiftW(ShW)) u_enq_lane_rot (
      .oh_i    (enq_ptr_q),
      .shift_i (ShW'(j)),
      .oh_o    (enq_lane_oh[j])
    );
  end

  for (genvar i = 0; i < DEQ_WIDTH; i++) begin : g_head_lane
    oh_rot_left #(.Width(QUEUE_SIZE), .ShiftW(ShW)) u_head_rot (
      .oh_i    (deq_ptr_q),
      .shift_i (ShW'(i)),
      .oh_o    (head_lane_oh[i])
    );
    assign head_valid[i]                          = count_q > CntW'(i);
    assign bus.head_oh[i*QUEUE_SIZE +: QUEUE_SIZE] = head_lane_oh[i];
  end

  oh_rot_left #(.Width(QUEUE_SIZE), .ShiftW(ShW)) u_enq_ptr_rot (
    .oh_i    (enq_ptr_q),
    .shift_i (nenq),
    .oh_o    (enq_ptr_rot)
  );

  oh_rot_left #(.Width(QUEUE_SIZE), .ShiftW(ShW)) u_deq_ptr_rot (
    .oh_i    (deq_ptr_q),
    .shift_i (ndeq),
    .oh_o    (deq_ptr_rot)
  );

  always_comb begin
    // head_valid is itself a prefix, so the AND leaves exactly the usable run.
    deq_vec                = '0;
    deq_vec[DEQ_WIDTH-1:0] = bus.deq_fire & head_valid;
    ndeq                   = ShW'(prefix_count(deq_vec));

    alloc_vec = '0;
    for (int j = 0; j < ENQ_WIDTH; j++) begin
      if (ShW'(j) < nenq) alloc_vec = alloc_vec | enq_lane_oh[j];
    end

    clr_vec  = '0;
    deq_mask = '0;
    for (int i = 0; i < DEQ_WIDTH; i++) begin
      deq_mask[i] = ShW'(i) < ndeq;
      if (deq_mask[i]) clr_vec = clr_vec | head_lane_oh[i];
    end
  end

  always_comb begin
    if (bus.flush) begin
      count_d   = '0;
      enq_ptr_d = SlotZero;
      deq_ptr_d = SlotZero;
      valid_d   = '0;
    end else begin
      count_d   = count_q + CntW'(nenq) - CntW'(ndeq);
      enq_ptr_d = enq_ptr_rot;
      deq_ptr_d = deq_ptr_rot;
      valid_d   = (valid_q & ~clr_vec) | alloc_vec;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q   <= '0;
      enq_ptr_q <= SlotZero;
      deq_ptr_q <= SlotZero;
      valid_q   <= '0;
    end else begin
      count_q   <= count_d;
      enq_ptr_q <= enq_ptr_d;
      deq_ptr_q <= deq_ptr_d;
      valid_q   <= valid_d;
    end
  end

  assign bus.enq_ready     = enq_ready;
  assign bus.enq_ptr_oh    = enq_ptr_q;
  assign bus.enq_alloc_vec = alloc_vec;
  assign bus.head_valid    = head_valid;
  assign bus.entry_valid   = valid_q;
  assign bus.count         = count_q;
  assign bus.empty         = count_q == '0;
  assign bus.full          = count_q == CntW'(QUEUE_SIZE);

`ifndef SYNTHESIS
  always @(posedge clock) begin
    if (reset_n) begin
      // Lanes past the valid run are dropped; this is legal but worth a note.
      assert ((bus.deq_fire & ~deq_mask) == '0)
        else $warning("io_multi_deq_ctrl: deq_fire=%b beyond valid run ignored", bus.deq_fire);
      assert (CntW'($countones(valid_q)) == count_q)
        else $error("io_multi_deq_ctrl: occupancy %b disagrees with count %0d",
                    valid_q, count_q);
    end
  end
`endif

endmodule

// File: tb/tb_io_multi_deq_ctrl.sv
// tb_io_multi_deq_ctrl: scoreboard bench for io_multi_deq_ctrl.
// The reference model is an age-ordered list of occupied slot numbers plus the
// next free slot; expected outputs are queued per cycle and checked on the
// falling edge by an independent monitor.
module tb_io_multi_deq_ctrl;

  localparam int unsigned QS = 8;
  localparam int unsigned EW = 2;
  localparam int unsigned DW = 2;

  typedef struct {
    logic           enq_ready;
    logic [QS-1:0]  enq_ptr_oh;
    logic [QS-1:0]  alloc;
    logic [DW-1:0]  head_valid;
    logic [DW*QS-1:0] head_oh;
    logic [QS-1:0]  entry_valid;
    logic [3:0]     count;
    logic           empty;
    logic           full;
  } exp_t;

  logic clock;
  logic reset_n;

  io_multi_deq_ctrl_if #(.QUEUE_SIZE(QS), .ENQ_WIDTH(EW), .DEQ_WIDTH(DW)) bus ();

  io_multi_deq_ctrl #(.QUEUE_SIZE(QS), .ENQ_WIDTH(EW), .DEQ_WIDTH(DW)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  exp_t exp_q[$];
  int   mq[$];      // occupied slots, oldest first
  int   tail;       // next slot to allocate
  int   vectors    = 0;
  int   miscompares = 0;

  function automatic exp_t build_exp(input logic [EW-1:0] er);
    exp_t e;
    int   nenq;
    int   head;
    e.enq_ready  = (QS - mq.size()) >= EW;
    nenq         = e.enq_ready ? $countones(er) : 0;
    head         = (mq.size() > 0) ? mq[0] : tail;
    e.count      = 4'(mq.size());
    e.empty      = mq.size() == 0;
    e.full       = mq.size() == QS;
    e.enq_ptr_oh = '0;
    e.enq_ptr_oh[tail] = 1'b1;
    e.alloc = '0;
    for (int j = 0; j < nenq; j++) e.alloc[(tail + j) % QS] = 1'b1;
    e.entry_valid = '0;
    foreach (mq[k]) e.entry_valid[mq[k]] = 1'b1;
    e.head_valid = '0;
    e.head_oh    = '0;
    for (int i = 0; i < DW; i++) begin
      e.head_valid[i] = mq.size() > i;
      e.head_oh[i*QS + ((head + i) % QS)] = 1'b1;
    end
    return e;
  endfunction

  // Called just after a rising edge; returns just after the next one.
  task automatic step(input logic fl, input logic [EW-1:0] er, input logic [DW-1:0] df);
    exp_t e;
    int   nenq;
    int   ndeq;
    bus.flush    = fl;
    bus.enq_req  = er;
    bus.deq_fire = df;
    e = build_exp(er);
    exp_q.push_back(e);
    nenq = e.enq_ready ? $countones(er) : 0;
    ndeq = 0;
    while (ndeq < DW && df[ndeq] && ndeq < mq.size()) ndeq++;
    if (fl) begin
      mq.delete();
      tail = 0;
    end else begin
      repeat (ndeq) void'(mq.pop_front());
      for (int j = 0; j < nenq; j++) begin
        mq.push_back(tail);
        tail = (tail + 1) % QS;
      end
    end
    @(posedge clock);
    #1;
  endtask

  // Drop reset mid-cycle, check the forced state while it is held, release off-edge.
  task automatic do_reset();
    bus.flush    = 1'b0;
    bus.enq_req  = '0;
    bus.deq_fire = '0;
    #2;
    reset_n = 1'b0;
    mq.delete();
    tail = 0;
    exp_q.push_back(build_exp('0));
    @(posedge clock);
    #3;
    reset_n = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, got, want);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("enq_ready",     16'(bus.enq_ready),     16'(e.enq_ready));
        chk("enq_ptr_oh",    16'(bus.enq_ptr_oh),    16'(e.enq_ptr_oh));
        chk("enq_alloc_vec", 16'(bus.enq_alloc_vec), 16'(e.alloc));
        chk("head_valid",    16'(bus.head_valid),    16'(e.head_valid));
        chk("head_oh",       16'(bus.head_oh),       16'(e.head_oh));
        chk("entry_valid",   16'(bus.entry_valid),   16'(e.entry_valid));
        chk("count",         16'(bus.count),         16'(e.count));
        chk("empty",         16'(bus.empty),         16'(e.empty));
        chk("full",          16'(bus.full),          16'(e.full));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: run did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int elen;
    int dlen;
    logic [EW-1:0] er;
    logic [DW-1:0] df;
    reset_n      = 1'b1;
    bus.flush    = 1'b0;
    bus.enq_req  = '0;
    bus.deq_fire = '0;
    tail         = 0;
    #1 reset_n = 1'b0;
    @(posedge clock);
    #1;
    do_reset();
    step(1'b0, 2'b00, 2'b00);

    // Fill: counts 0,2,4,6 seen pre-edge, then full with 0xFF occupied.
    repeat (4) step(1'b0, 2'b11, 2'b00);
    step(1'b0, 2'b11, 2'b00);          // full: request refused, no allocation
    step(1'b0, 2'b00, 2'b00);

    // Walk deq pointer to slot 6 with count 4, then dequeue across the wrap.
    repeat (3) step(1'b0, 2'b00, 2'b11);
    step(1'b0, 2'b11, 2'b00);
    step(1'b0, 2'b00, 2'b11);          // head_oh 0x40/0x80 here
    step(1'b0, 2'b00, 2'b00);          // head_oh 0x01/0x02, count 2

    // Simultaneous traffic at count 6.
    repeat (2) step(1'b0, 2'b11, 2'b00);
    step(1'b0, 2'b11, 2'b01);
    step(1'b0, 2'b00, 2'b00);          // count 7

    // Flush beats same-cycle enqueue and dequeue.
    step(1'b1, 2'b11, 2'b11);
    step(1'b0, 2'b00, 2'b00);

    // No bypass; a non-prefix dequeue is ignored.
    step(1'b0, 2'b01, 2'b00);
    step(1'b0, 2'b00, 2'b10);
    step(1'b0, 2'b00, 2'b00);

    repeat (300) begin
      elen = $urandom_range(0, EW);
      dlen = $urandom_range(0, (mq.size() < DW) ? mq.size() : DW);
      er   = EW'((1 << elen) - 1);
      df   = DW'((1 << dlen) - 1);
      step(($urandom_range(0, 31) == 0), er, df);
    end

    // Reset in the middle of traffic, then resume from empty.
    do_reset();
    repeat (40) begin
      elen = $urandom_range(0, EW);
      dlen = $urandom_range(0, (mq.size() < DW) ? mq.size() : DW);
      er   = EW'((1 << elen) - 1);
      df   = DW'((1 << dlen) - 1);
      step(1'b0, er, df);
    end

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clock);
    #1;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
